mem_access_splitter: RTL and testbench

//  Parametrised load/store sequencer between the execute stage and the data-memory port.

---
 rtl/mem_split_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_splitter.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access_splitter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_split_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_split_pkg
//  Purpose  : Shared types and helpers for the load/store access splitter:
//             sequencer state encoding, access-size codes and the byte-enable
//             mask generator used for both halves of a split access.
//  Revision : 1.0  initial release
// ============================================================================
package mem_split_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BEAT0  = 3'd1,
      BEAT1  = 3'd2,
      RDWAIT = 3'd3,
      DONE   = 3'd4
   } state_t;

   // req_size codes (log2 of the access width in bytes)
   localparam int SZ_BYTE  = 0;
   localparam int SZ_HALF  = 1;
   localparam int SZ_WORD  = 2;
   localparam int SZ_DWORD = 3;

   // Widest bus the mask helper supports (512-bit data path)
   localparam int MAX_BYTES = 64;
   localparam int MASK_W    = 2 * MAX_BYTES;

   // Byte enables of one beat: the low half is (mask << off) and the high
   // half is whatever spilled past the bus width, i.e. mask >> (nbytes-off).
   function automatic logic [MAX_BYTES-1:0] be_mask(input int size, input int off,
                                                    input logic hi_half, input int nbytes);
      logic [MASK_W-1:0] m;
      int n;
      n = (size >= 16) ? nbytes : (1 << size);
      if (n > nbytes) n = nbytes;
      m = (MASK_W'(1) << n) - MASK_W'(1);
      m = m << off;
      if (hi_half) m = m >> nbytes;
      return MAX_BYTES'(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Combinational lane steering. Moves right-justified store data
//             and byte enables onto bus lanes for the low or high beat, and
//             merges the two read halves back into right-justified load data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_lane_align
   import mem_split_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int SIZE_W = 2,
   localparam int BYTES  = DATA_W / 8,
   localparam int OFF_W  = $clog2(BYTES)
) (
   input  logic [OFF_W-1:0]  off_i,
   input  logic [SIZE_W-1:0] size_i,
   input  logic              hi_i,
   input  logic              cross_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata0_i,
   input  logic [DATA_W-1:0] rdata1_i,
   output logic [BYTES-1:0]  be_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o
);

   int                sh_lo;
   int                sh_hi;
   int                nb;
   logic [DATA_W-1:0] lo_part;
   logic [DATA_W-1:0] hi_part;
   logic [DATA_W-1:0] dmask;

   assign be_o = BYTES'(be_mask(int'(size_i), int'(off_i), hi_i, BYTES));

   // Lane shifts for store data and the two-half load merge
   always_comb begin
      sh_lo   = 8 * int'(off_i);
      sh_hi   = DATA_W - sh_lo;
      nb      = (int'(size_i) >= 16) ? BYTES : (1 << int'(size_i));
      if (nb > BYTES) nb = BYTES;
      wdata_o = hi_i ? (wdata_i >> sh_hi) : (wdata_i << sh_lo);
      lo_part = rdata0_i >> sh_lo;
      hi_part = cross_i ? (rdata1_i << sh_hi) : '0;
      dmask   = {DATA_W{1'b1}} >> (DATA_W - 8 * nb);
      rdata_o = (lo_part | hi_part) & dmask;
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_splitter
//  Purpose  : Load/store sequencer between execute and the data-memory port.
//             Issues one or two bus-aligned beats per access, merges split
//             read data, supports backpressure, flush with read draining and
//             a one-cycle completion pulse.
//  Options  : MISALIGN_EXC_EN - crossing accesses complete with resp_err
//             instead of being split.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_splitter
   import mem_split_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int SIZE_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [SIZE_W-1:0]   req_size,
   input  logic                req_we,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                flush,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   state_t              state_q;
   logic [OFF_W-1:0]    off_q;
   logic [SIZE_W-1:0]   size_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                cross_q;
   logic [DATA_W-1:0]   rdata0_q;
   logic [1:0]          acc_q;     // read beats accepted by memory
   logic [1:0]          rx_q;      // read beats returned
   logic [1:0]          drain_q;   // orphaned reads still owed after a flush
   logic                mem_valid_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_we_q;
   logic [BYTES-1:0]    mem_be_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic                resp_err_q;

   logic                sel_req;
   logic [OFF_W-1:0]    al_off;
   logic [SIZE_W-1:0]   al_size;
   logic [DATA_W-1:0]   al_wdata;
   logic [DATA_W-1:0]   al_rdata0;
   logic [BYTES-1:0]    al_be;
   logic [DATA_W-1:0]   al_wlane;
   logic [DATA_W-1:0]   al_rdata;
   logic                req_cross;
   logic                req_illegal;
   logic                req_err;
   logic                beat_acc;
   logic                rd_hit;
   logic                rd_done;
   logic [1:0]          need;

   // In IDLE the aligner prepares beat 0 from the live request; afterwards it
   // works on the latched access (high half, read merge).
   assign sel_req   = (state_q == IDLE);
   assign al_off    = sel_req ? req_addr[OFF_W-1:0] : off_q;
   assign al_size   = sel_req ? req_size : size_q;
   assign al_wdata  = sel_req ? req_wdata : wdata_q;
   assign al_rdata0 = (rx_q == 2'd0) ? mem_rdata : rdata0_q;

   mem_lane_align #(
      .DATA_W (DATA_W),
      .SIZE_W (SIZE_W)
   ) u_align (
      .off_i    (al_off),
      .size_i   (al_size),
      .hi_i     (!sel_req),
      .cross_i  (cross_q),
      .wdata_i  (al_wdata),
      .rdata0_i (al_rdata0),
      .rdata1_i (mem_rdata),
      .be_o     (al_be),
      .wdata_o  (al_wlane),
      .rdata_o  (al_rdata)
   );

   assign req_illegal = (int'(req_size) > OFF_W);
   assign req_cross   = (int'(req_addr[OFF_W-1:0]) + (1 << int'(req_size))) > BYTES;
`ifdef MISALIGN_EXC_EN
   assign req_err     = req_illegal || req_cross;
`else
   assign req_err     = req_illegal;
`endif

   assign need     = cross_q ? 2'd2 : 2'd1;
   assign beat_acc = mem_valid_q && mem_ready;
   assign rd_hit   = mem_rvalid && !we_q && ((state_q == BEAT1) || (state_q == RDWAIT));
   assign rd_done  = rd_hit && ((rx_q + 2'd1) == need);

   assign req_ready  = (state_q == IDLE) && (drain_q == 2'd0);
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // Access sequencer: accept, issue beats, collect reads, respond or flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         off_q        <= '0;
         size_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         cross_q      <= 1'b0;
         rdata0_q     <= '0;
         acc_q        <= 2'd0;
         rx_q         <= 2'd0;
         drain_q      <= 2'd0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         if (flush && (state_q != IDLE)) begin
            // A beat handshaking this cycle still counts as issued
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            drain_q     <= acc_q + {1'b0, beat_acc && !we_q} - rx_q - {1'b0, rd_hit};
         end else begin
            if (rd_hit) begin
               rx_q <= rx_q + 2'd1;
               if (rx_q == 2'd0) rdata0_q <= mem_rdata;
            end
            case (state_q)
               IDLE: begin
                  if (mem_rvalid && (drain_q != 2'd0)) drain_q <= drain_q - 2'd1;
                  if (req_valid && req_ready) begin
                     off_q   <= req_addr[OFF_W-1:0];
                     size_q  <= req_size;
                     we_q    <= req_we;
                     wdata_q <= req_wdata;
                     cross_q <= req_cross;
                     acc_q   <= 2'd0;
                     rx_q    <= 2'd0;
                     if (req_err) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                     end else begin
                        state_q     <= BEAT0;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_we_q    <= req_we;
                        mem_be_q    <= al_be;
                        mem_wdata_q <= al_wlane;
                     end
                  end
               end
               BEAT0: begin
                  if (beat_acc) begin
                     if (!we_q) acc_q <= 2'd1;
                     if (cross_q) begin
                        state_q     <= BEAT1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(BYTES);
                        mem_be_q    <= al_be;
                        mem_wdata_q <= al_wlane;
                     end else begin
                        mem_valid_q <= 1'b0;
                        if (we_q) begin
                           state_q      <= DONE;
                           resp_valid_q <= 1'b1;
                           resp_rdata_q <= '0;
                        end else begin
                           state_q <= RDWAIT;
                        end
                     end
                  end
               end
               BEAT1: begin
                  if (beat_acc) begin
                     mem_valid_q <= 1'b0;
                     if (we_q) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                     end else begin
                        acc_q   <= 2'd2;
                        state_q <= RDWAIT;
                     end
                  end
               end
               RDWAIT: begin
                  if (rd_done) begin
                     state_q      <= IDLE;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= al_rdata;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_splitter
//  Purpose  : Randomised self-checking bench for mem_access_splitter with a
//             byte-level reference model, a reactive memory responder and
//             directed split, wrap, illegal-size and flush scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_splitter;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_we = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        flush = 1'b0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   int    last_evt = 0;
   int    rdy_mode = 0;     // 0 random, 1 always, 2 never, 3 stall 3 cycles per beat
   int    rd_dmin = 0;
   int    rd_dmax = 3;
   beat_t exp_beats[$];
   rd_t   rq[$];

   mem_access_splitter #(.DATA_W(32), .ADDR_W(32), .SIZE_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_we     (req_we),
      .req_wdata  (req_wdata),
      .flush      (flush),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: runs after the main driver each cycle
   initial begin : responder
      beat_t       b;
      logic        r;
      logic        pv = 1'b0;
      logic        pr = 1'b0;
      logic [31:0] pa = '0;
      logic [3:0]  pbe = '0;
      logic        pwe = 1'b0;
      logic [31:0] pwd = '0;
      int          stall = 0;
      forever begin
         @(posedge clk);
         #2;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (!rst) begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rq[0].data;
               void'(rq.pop_front());
               last_evt = cyc;
            end
            if (pv && !pr && mem_valid) begin
               check("hold_addr", mem_addr, pa);
               check("hold_be", mem_be, pbe);
               check("hold_we", mem_we, pwe);
               check("hold_wdata", mem_wdata, pwd);
            end
            case (rdy_mode)
               0:       r = ($urandom_range(0, 2) != 0);
               1:       r = 1'b1;
               3:       r = (stall >= 3);
               default: r = 1'b0;
            endcase
            mem_ready = r;
            if (mem_valid && !r) stall++;
            if (mem_valid && r) begin
               stall = 0;
               check("beat_expected", exp_beats.size() > 0, 1);
               if (exp_beats.size() > 0) begin
                  b = exp_beats.pop_front();
                  check("beat_addr", mem_addr, b.addr);
                  check("beat_be", mem_be, b.be);
                  check("beat_we", mem_we, b.we);
                  if (b.we) check("beat_wdata", mem_wdata, b.wdata);
               end
               if (!mem_we)
                  rq.push_back('{memword(mem_addr), cyc + 1 + $urandom_range(rd_dmin, rd_dmax)});
               else
                  last_evt = cyc;
            end
            pv = mem_valid; pr = r; pa = mem_addr; pbe = mem_be; pwe = mem_we; pwd = mem_wdata;
         end
      end
   end

   // One access through the reference model, the DUT and the responder
   task automatic do_access(input logic [31:0] a, input logic [1:0] sz, input logic we,
                            input logic [31:0] wd_in);
      beat_t       bb[2];
      int          nb;
      int          n;
      int          ln;
      int          w;
      int          acc_cyc;
      logic [31:0] b;
      logic [31:0] ba;
      logic [31:0] wd;
      logic [31:0] wrd;
      logic [31:0] exp_rd;
      logic [63:0] m64;
      logic        exp_err;
      n       = 1 << sz;
      exp_err = (sz > 2'd2);
`ifdef MISALIGN_EXC_EN
      if ((a & ~32'h3) != ((a + 32'(n) - 32'd1) & ~32'h3)) exp_err = 1'b1;
`endif
      m64    = (64'd1 << (8 * n)) - 64'd1;
      wd     = we ? (wd_in & m64[31:0]) : wd_in;
      exp_rd = '0;
      nb     = 0;
      if (!exp_err) begin
         for (int i = 0; i < n; i++) begin
            b  = a + 32'(i);
            ba = b & ~32'h3;
            ln = int'(b[1:0]);
            if (nb == 0 || bb[nb-1].addr != ba) begin
               bb[nb] = '{ba, 4'b0000, we, 32'h0};
               nb++;
            end
            bb[nb-1].be[ln]          = 1'b1;
            bb[nb-1].wdata[8*ln +: 8] = wd[8*i +: 8];
            wrd                      = memword(ba);
            exp_rd[8*i +: 8]         = wrd[8*ln +: 8];
         end
      end
      if (we) exp_rd = '0;
      for (int i = 0; i < nb; i++) exp_beats.push_back(bb[i]);

      w = 0;
      while (!req_ready && w < 60) begin tick(); w++; end
      check("req_ready_wait", req_ready, 1);
      req_valid = 1'b1; req_addr = a; req_size = sz; req_we = we; req_wdata = wd;
      acc_cyc   = cyc;
      tick();
      req_valid = 1'b0;
      if (exp_err) last_evt = acc_cyc;
      w = 0;
      while (!resp_valid && w < 60) begin tick(); w++; end
      check("resp_seen", resp_valid, 1);
      if (resp_valid) begin
         check("resp_err", resp_err, exp_err);
         if (!exp_err) check("resp_rdata", resp_rdata, exp_rd);
         check("resp_latency", cyc, last_evt + 1);
         check("beats_left", exp_beats.size(), 0);
      end
      tick();
      check("resp_pulse", resp_valid, 0);
      exp_beats.delete();
   endtask

   initial begin : main
      int          w;
      int          k;
      logic        bad;
      logic [31:0] a;
      logic [1:0]  sz;
      #3;
      check("rst_req_ready", req_ready, 1);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Directed accesses
      rdy_mode = 1;
      do_access(32'h0000_0100, 2'd2, 1'b1, 32'hDEAD_BEEF);
      do_access(32'h0000_0103, 2'd2, 1'b1, 32'h1122_3344);
      do_access(32'h0000_0207, 2'd1, 1'b0, 32'h0);
      do_access(32'h0000_0206, 2'd1, 1'b0, 32'h0);
      do_access(32'h0000_0003, 2'd0, 1'b1, 32'h0000_00A5);
      do_access(32'hFFFF_FFFE, 2'd2, 1'b1, 32'hCAFE_F00D);
      do_access(32'hFFFF_FFFD, 2'd2, 1'b0, 32'h0);
      do_access(32'h0000_0040, 2'd3, 1'b1, 32'h1234_5678);
      rdy_mode = 3;
      do_access(32'h0000_0103, 2'd2, 1'b1, 32'h5566_7788);
      do_access(32'h0000_0301, 2'd2, 1'b0, 32'h0);

      // Flush in IDLE has no effect
      flush = 1'b1; tick(); flush = 1'b0;
      check("idle_flush_ready", req_ready, 1);
      check("idle_flush_valid", mem_valid, 0);

`ifndef MISALIGN_EXC_EN
      // Flush while the second half of a split load is pending
      rdy_mode = 1; rd_dmin = 6; rd_dmax = 6;
      exp_beats.push_back('{32'h0000_0204, 4'b1000, 1'b0, 32'h0});
      req_valid = 1'b1; req_addr = 32'h0000_0207; req_size = 2'd1; req_we = 1'b0;
      k = cyc;
      tick();
      req_valid = 1'b0;
      check("fl_beat0_valid", mem_valid, 1);
      tick();
      check("fl_beat1_valid", mem_valid, 1);
      check("fl_beat1_addr", mem_addr, 32'h0000_0208);
      rdy_mode = 2;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_mem_valid", mem_valid, 0);
      check("fl_req_ready", req_ready, 0);
      check("fl_beats_left", exp_beats.size(), 0);
      w = 0; bad = 1'b0;
      while (!req_ready && w < 40) begin
         if (resp_valid || mem_valid) bad = 1'b1;
         tick(); w++;
      end
      check("fl_quiet", bad, 0);
      check("fl_drain_release", cyc, last_evt + 1);
      check("fl_drain_cycle", last_evt, k + 8);
      check("fl_no_resp", resp_valid, 0);
      check("fl_rq_empty", rq.size(), 0);
      exp_beats.delete();
`endif

      // Randomised traffic with backpressure and variable read latency
      rd_dmin = 0; rd_dmax = 3;
      for (int t = 0; t < 200; t++) begin
         a = $urandom;
         if ($urandom_range(0, 5) == 0) a[31:4] = 28'hFFF_FFFF;
         sz       = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rdy_mode = ($urandom_range(0, 3) == 0) ? 3 : 0;
         do_access(a, sz, 1'($urandom_range(0, 1)), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
